wb_spi_master: RTL

//  Wishbone-slave SPI master (mode 0, MSB first, 8-bit frames) inside user_proj_example.
//  It drives the SPI_MOSI/SCLK/CSB GPIO pins and samples SPI_MISO through io_in/io_out/io_oeb.
//  The management SoC programs it over WB; it raises an IRQ on frame completion.

---
 rtl/wb_spi_master_if.sv | 20 ++
 rtl/wb_spi_master.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/wb_spi_master_if.sv
// Wishbone slave bus bundle for wb_spi_master (classic single-cycle ack).
interface wb_spi_master_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_spi_master.sv
// Wishbone-programmed SPI master: mode 0, MSB first, 8-bit frames, level IRQ on completion.
module wb_spi_master #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DIV_W     = 16
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_spi_master_if.slave    wbs,
    input  logic              spi_miso,
    output logic              spi_sclk,
    output logic              spi_mosi,
    output logic              spi_csb,
    output logic [3:0]        spi_oeb,
    output logic              busy_led,
    output logic              irq
);
    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL} state_t;

    localparam logic [DIV_W-1:0] ONE = 1;

    state_t           state_q, state_d;
    logic             ack_q, ack_d;
    logic             en_q, en_d, irq_en_q, irq_en_d;
    logic [DIV_W-1:0] div_q, div_d, h_q, h_d, cnt_q, cnt_d;
    logic [3:0]       half_q, half_d;
    logic [7:0]       sh_q, sh_d, rx_q, rx_d;
    logic             samp_q, samp_d;
    logic             done_q, done_d, ovr_q, ovr_d;
    logic             sclk_q, sclk_d, mosi_q, mosi_d, csb_q, csb_d;

    logic [7:0]  off;
    logic        in_win, wr, busy, tx_go, abort, done_set, done_clr, ovr_clr;
    logic [31:0] rdata;

    assign off    = wbs.wbs_adr_i[7:0];
    assign in_win = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wr     = ack_q & wbs.wbs_cyc_i & wbs.wbs_stb_i & wbs.wbs_we_i;
    assign busy   = (state_q != S_IDLE);
    assign tx_go  = wr && (off == 8'h08) && wbs.wbs_sel_i[0];

    always_comb begin
        ack_d    = wbs.wbs_cyc_i & wbs.wbs_stb_i & in_win & ~ack_q;
        state_d  = state_q;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        div_d    = div_q;
        h_d      = h_q;
        cnt_d    = cnt_q;
        half_d   = half_q;
        sh_d     = sh_q;
        rx_d     = rx_q;
        samp_d   = samp_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        csb_d    = csb_q;
        done_set = 1'b0;
        done_clr = 1'b0;
        ovr_clr  = 1'b0;

        if (wr && off == 8'h00 && wbs.wbs_sel_i[0]) begin
            en_d     = wbs.wbs_dat_i[0];
            irq_en_d = wbs.wbs_dat_i[1];
        end
        if (wr && off == 8'h04) begin
            for (int i = 0; i < DIV_W; i++)
                if (wbs.wbs_sel_i[i/8]) div_d[i] = wbs.wbs_dat_i[i];
        end
        if (wr && off == 8'h10 && wbs.wbs_sel_i[0]) begin
            done_clr = wbs.wbs_dat_i[1];
            ovr_clr  = wbs.wbs_dat_i[2];
        end

        // Clearing EN wins over any frame progress, including the final TRAIL cycle.
        abort = busy && !en_d;

        if (abort) begin
            state_d = S_IDLE;
            csb_d   = 1'b1;
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (tx_go && en_q) begin
                    state_d = S_LEAD;
                    sh_d    = wbs.wbs_dat_i[7:0];
                    mosi_d  = wbs.wbs_dat_i[7];
                    csb_d   = 1'b0;
                    sclk_d  = 1'b0;
                    h_d     = div_q;
                    cnt_d   = div_q;
                end
                S_LEAD: if (cnt_q == '0) begin
                    state_d = S_SHIFT;
                    sclk_d  = 1'b1;
                    samp_d  = spi_miso;
                    cnt_d   = h_q;
                    half_d  = 4'd0;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
                S_SHIFT: if (cnt_q == '0) begin
                    cnt_d = h_q;
                    if (half_q == 4'd15) begin
                        state_d = S_TRAIL;
                    end else begin
                        half_d = half_q + 4'd1;
                        sclk_d = ~sclk_q;
                        // Falling edge: shift in the bit sampled at the preceding rise.
                        if (sclk_q) begin
                            sh_d   = {sh_q[6:0], samp_q};
                            mosi_d = sh_q[6];
                        end else begin
                            samp_d = spi_miso;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
                S_TRAIL: if (cnt_q == '0) begin
                    state_d  = S_IDLE;
                    csb_d    = 1'b1;
                    mosi_d   = 1'b0;
                    rx_d     = sh_q;
                    done_set = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        done_d = (done_q & ~done_clr) | done_set;
        ovr_d  = (ovr_q & ~ovr_clr) | (tx_go & busy);
    end

    always_comb begin
        rdata = 32'h0;
        case (off)
            8'h00:   rdata[1:0] = {irq_en_q, en_q};
            8'h04:   rdata      = 32'(div_q);
            8'h0C:   rdata[7:0] = rx_q;
            8'h10:   rdata[2:0] = {ovr_q, done_q, busy};
            default: rdata      = 32'h0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            ack_q    <= 1'b0;
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            div_q    <= '0;
            h_q      <= '0;
            cnt_q    <= '0;
            half_q   <= 4'd0;
            sh_q     <= 8'h00;
            rx_q     <= 8'h00;
            samp_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            csb_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            div_q    <= div_d;
            h_q      <= h_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            sh_q     <= sh_d;
            rx_q     <= rx_d;
            samp_q   <= samp_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            csb_q    <= csb_d;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = ack_q ? rdata : 32'h0;
    assign spi_sclk      = sclk_q;
    assign spi_mosi      = mosi_q;
    assign spi_csb       = csb_q;
    assign spi_oeb       = 4'b0010;
    assign busy_led      = busy;
    assign irq           = done_q & irq_en_q;
endmodule
